// File: rtl/keccak_pkg.sv
// Shared Keccak definitions: data-path widths, mode encodings and the squeeze
// controller state type.
//   DWIDTH            : squeeze output beat width in bits
//   AXIS_KEEP_WIDTH   : byte-enable width of one beat
//   RATE_WIDTH        : width able to hold the largest rate in bytes (168)
//   MODE_SEL_WIDTH    : width of the mode selector
//   BYTE_ABSORB_WIDTH : width of byte offsets into the rate window
package keccak_pkg;

    localparam int DWIDTH            = 256;
    localparam int AXIS_KEEP_WIDTH   = DWIDTH / 8;
    localparam int RATE_WIDTH        = 8;
    localparam int MODE_SEL_WIDTH    = 3;
    localparam int BYTE_ABSORB_WIDTH = 8;

    localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_224 = 3'd0;
    localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_256 = 3'd1;
    localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_384 = 3'd2;
    localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_512 = 3'd3;
    localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHAKE128 = 3'd4;
    localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHAKE256 = 3'd5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SQUEEZE   = 2'd1,
        PERM_WAIT = 2'd2,
        DRAIN     = 2'd3
    } squeeze_state_e;

    // Extendable-output modes terminate on an explicit stop instead of a
    // fixed digest length.
    function automatic logic is_shake(input logic [MODE_SEL_WIDTH-1:0] mode);
        return (mode == MODE_SHAKE128) || (mode == MODE_SHAKE256);
    endfunction

endpackage

// File: rtl/keccak_squeeze_ctrl_axis_out_reg.sv
// axis_out_reg: one-entry registered AXI-Stream master slot.
//   clk, rst_n      : clock, asynchronous active-low reset
//   load            : capture in_* into the slot (honoured only when slot_free)
//   in_data/keep/last : beat to capture
//   tready          : sink ready
//   tdata/tkeep/tlast/tvalid : registered AXI-Stream outputs
//   slot_free       : slot is empty or is being emptied this cycle
// With ZERO_PAD=1 the data bytes whose keep bit is clear are stored as 0x00.
module axis_out_reg #(
    parameter int DATA_W   = 256,
    parameter bit ZERO_PAD = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [DATA_W/8-1:0] in_keep,
    input  logic                in_last,
    input  logic                tready,
    output logic [DATA_W-1:0]   tdata,
    output logic [DATA_W/8-1:0] tkeep,
    output logic                tlast,
    output logic                tvalid,
    output logic                slot_free
);

    localparam int KEEP_W = DATA_W / 8;

    logic [DATA_W-1:0] pad_data;
    logic [DATA_W-1:0] tdata_reg;
    logic [KEEP_W-1:0] tkeep_reg;
    logic              tlast_reg;
    logic              tvalid_reg;

    generate
        for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_pad
            if (ZERO_PAD) begin : g_zero
                assign pad_data[gi*8 +: 8] = in_keep[gi] ? in_data[gi*8 +: 8] : 8'h00;
            end else begin : g_pass
                assign pad_data[gi*8 +: 8] = in_data[gi*8 +: 8];
            end
        end
    endgenerate

    assign slot_free = !tvalid_reg || tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdata_reg  <= '0;
            tkeep_reg  <= '0;
            tlast_reg  <= 1'b0;
            tvalid_reg <= 1'b0;
        end else if (slot_free) begin
            // An accepted beat with nothing new behind it empties the slot.
            tvalid_reg <= load;
            if (load) begin
                tdata_reg <= pad_data;
                tkeep_reg <= in_keep;
                tlast_reg <= in_last;
            end
        end
    end

    assign tdata  = tdata_reg;
    assign tkeep  = tkeep_reg;
    assign tlast  = tlast_reg;
    assign tvalid = tvalid_reg;

endmodule

// File: rtl/keccak_squeeze_ctrl.sv
// keccak_squeeze_ctrl: sequences the squeeze phase behind keccak_output_unit.
// Owns the byte offset into the rate window, registers each combinational
// beat into an AXI-Stream master slot, requests a permutation when the rate
// window is used up, and ends on the digest length (SHA3) or stop_i (SHAKE).
//   start_i / keccak_mode_i       : begin squeezing in the given mode
//   stop_i                        : SHAKE end-of-stream request
//   bytes_squeezed_o              : offset presented to the output unit
//   unit_*_i                      : combinational beat from the output unit
//   perm_start_o / perm_done_i    : permutation request / completion pulses
//   m_axis_*                      : registered AXI-Stream output
//   busy_o / done_o               : not idle / final beat accepted pulse
module keccak_squeeze_ctrl
    import keccak_pkg::*;
#(
    parameter bit ZERO_PAD = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic                         stop_i,
    input  logic [MODE_SEL_WIDTH-1:0]    keccak_mode_i,
    output logic [BYTE_ABSORB_WIDTH-1:0] bytes_squeezed_o,
    input  logic [DWIDTH-1:0]            unit_data_i,
    input  logic [AXIS_KEEP_WIDTH-1:0]   unit_keep_i,
    input  logic                         unit_last_i,
    input  logic [BYTE_ABSORB_WIDTH-1:0] unit_bytes_next_i,
    input  logic                         unit_perm_needed_i,
    output logic                         perm_start_o,
    input  logic                         perm_done_i,
    output logic [DWIDTH-1:0]            m_axis_tdata_o,
    output logic [AXIS_KEEP_WIDTH-1:0]   m_axis_tkeep_o,
    output logic                         m_axis_tlast_o,
    output logic                         m_axis_tvalid_o,
    input  logic                         m_axis_tready_i,
    output logic                         busy_o,
    output logic                         done_o
);

    squeeze_state_e               state_reg, state_next;
    logic [BYTE_ABSORB_WIDTH-1:0] bytes_reg, bytes_next;
    logic                         stop_pend_reg, stop_pend_next;
    logic                         perm_start_reg, perm_start_next;
    logic                         done_reg, done_next;

    logic slot_free;
    logic load;
    logic stop_req;
    logic beat_last;

    // stop_i has no meaning for fixed-length digests.
    assign stop_req  = stop_i && is_shake(keccak_mode_i);
    // A stop seen during a stall or a permutation is remembered so the next
    // captured beat closes the stream.
    assign beat_last = unit_last_i || stop_pend_reg || stop_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            bytes_reg      <= '0;
            stop_pend_reg  <= 1'b0;
            perm_start_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bytes_reg      <= bytes_next;
            stop_pend_reg  <= stop_pend_next;
            perm_start_reg <= perm_start_next;
            done_reg       <= done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        bytes_next      = bytes_reg;
        stop_pend_next  = stop_pend_reg;
        perm_start_next = 1'b0;
        done_next       = 1'b0;
        load            = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    bytes_next     = '0;
                    stop_pend_next = 1'b0;
                    state_next     = SQUEEZE;
                end
            end
            SQUEEZE: begin
                if (slot_free) begin
                    load = 1'b1;
                    // The final beat wins over an exhausted rate window:
                    // no permutation is wasted after the stream ends.
                    if (beat_last) begin
                        state_next = DRAIN;
                    end else if (unit_perm_needed_i) begin
                        perm_start_next = 1'b1;
                        state_next      = PERM_WAIT;
                    end else begin
                        bytes_next = unit_bytes_next_i;
                    end
                end else if (stop_req) begin
                    stop_pend_next = 1'b1;
                end
            end
            PERM_WAIT: begin
                if (stop_req) begin
                    stop_pend_next = 1'b1;
                end
                if (perm_done_i) begin
                    bytes_next = '0;
                    state_next = SQUEEZE;
                end
            end
            DRAIN: begin
                if (m_axis_tvalid_o && m_axis_tready_i) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    axis_out_reg #(
        .DATA_W   (DWIDTH),
        .ZERO_PAD (ZERO_PAD)
    ) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .in_data   (unit_data_i),
        .in_keep   (unit_keep_i),
        .in_last   (beat_last),
        .tready    (m_axis_tready_i),
        .tdata     (m_axis_tdata_o),
        .tkeep     (m_axis_tkeep_o),
        .tlast     (m_axis_tlast_o),
        .tvalid    (m_axis_tvalid_o),
        .slot_free (slot_free)
    );

    assign bytes_squeezed_o = bytes_reg;
    assign perm_start_o     = perm_start_reg;
    assign done_o           = done_reg;
    assign busy_o           = (state_reg != IDLE);

endmodule

// File: tb/tb_keccak_squeeze_ctrl.sv
`timescale 1ns/1ps
module tb_keccak_squeeze_ctrl;
    import keccak_pkg::*;

    localparam int DW = DWIDTH;
    localparam int KW = DWIDTH / 8;
    localparam int BW = BYTE_ABSORB_WIDTH;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      start_i = 1'b0;
    logic                      stop_i = 1'b0;
    logic [MODE_SEL_WIDTH-1:0] mode_i = '0;
    logic [BW-1:0]             bytes_sq;
    logic [DW-1:0]             unit_data;
    logic [KW-1:0]             unit_keep;
    logic                      unit_last;
    logic [BW-1:0]             unit_next;
    logic                      unit_perm;
    logic                      perm_start;
    logic                      perm_done = 1'b0;
    logic [DW-1:0]             tdata;
    logic [KW-1:0]             tkeep;
    logic                      tlast, tvalid, busy, done;
    logic                      tready = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int blk = 0;
    int seed = 0;
    int perm_lat = 4;

    keccak_squeeze_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_i            (start_i),
        .stop_i             (stop_i),
        .keccak_mode_i      (mode_i),
        .bytes_squeezed_o   (bytes_sq),
        .unit_data_i        (unit_data),
        .unit_keep_i        (unit_keep),
        .unit_last_i        (unit_last),
        .unit_bytes_next_i  (unit_next),
        .unit_perm_needed_i (unit_perm),
        .perm_start_o       (perm_start),
        .perm_done_i        (perm_done),
        .m_axis_tdata_o     (tdata),
        .m_axis_tkeep_o     (tkeep),
        .m_axis_tlast_o     (tlast),
        .m_axis_tvalid_o    (tvalid),
        .m_axis_tready_i    (tready),
        .busy_o             (busy),
        .done_o             (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rate_of(input int m);
        case (m)
            0: return 144;
            1: return 136;
            2: return 104;
            3: return 72;
            4: return 168;
            default: return 136;
        endcase
    endfunction

    function automatic int dlen_of(input int m);
        case (m)
            0: return 28;
            1: return 32;
            2: return 48;
            3: return 64;
            default: return 0;
        endcase
    endfunction

    function automatic bit shake_of(input int m);
        return (m == 4) || (m == 5);
    endfunction

    // Keccak state byte k of rate block b (block index advances per permutation).
    function automatic logic [7:0] pat(input int sd, input int b, input int k);
        return 8'((sd + k + 91 * b) & 255);
    endfunction

    // Stand-in for keccak_output_unit: slices the current rate block at the
    // controller's offset. Bytes outside the window carry junk.
    always_comb begin : unit_model
        int off, n, rate, dlen;
        off  = int'(bytes_sq);
        rate = rate_of(int'(mode_i));
        dlen = dlen_of(int'(mode_i));
        n    = rate - off;
        if (n > KW) n = KW;
        if (!shake_of(int'(mode_i)) && (dlen - off < n)) n = dlen - off;
        if (n < 0) n = 0;
        unit_data = '0;
        unit_keep = '0;
        for (int i = 0; i < KW; i++) begin
            if (i < n) begin
                unit_data[i*8 +: 8] = pat(seed, blk, off + i);
                unit_keep[i]        = 1'b1;
            end else begin
                unit_data[i*8 +: 8] = 8'hC3;
            end
        end
        unit_last = !shake_of(int'(mode_i)) && (off + n >= dlen);
        unit_next = BW'(off + n);
        unit_perm = (off + n >= rate);
    end

    // Permutation core stand-in: answers each request after perm_lat cycles.
    initial begin : perm_responder
        forever begin
            @(negedge clk);
            if (perm_start === 1'b1) begin
                repeat (perm_lat) @(posedge clk);
                #1 perm_done = 1'b1;
                @(posedge clk);
                #1 perm_done = 1'b0;
                blk = blk + 1;
            end
        end
    end

    task automatic run_stream(input string name, input int mode, input int sd,
                              input int ready_mode, input int stop_beat,
                              input bit stop_in_perm, input bit rand_start);
        logic [DW-1:0] od[$];
        logic [KW-1:0] okp[$];
        logic          ol[$];
        int            oa[$];
        logic [DW-1:0] ed;
        logic [KW-1:0] ek;
        int s, accepted, nperm, stop_cyc, last_hs_cyc, done_cyc;
        int fin, off, b, n, rate, dlen, exp_perm, exp_beats;
        bit stop_sent, in_perm, prev_valid, prev_hs, prev_pd, got_done, last_seen, last_hs_final, is_last, shk;

        accepted = 0; nperm = 0; stop_cyc = 0; last_hs_cyc = -10; done_cyc = -1;
        stop_sent = 0; in_perm = 0; prev_valid = 0; prev_hs = 0; prev_pd = 0;
        got_done = 0; last_seen = 0; last_hs_final = 0;
        shk  = shake_of(mode);
        rate = rate_of(mode);
        dlen = dlen_of(mode);

        @(posedge clk); #1;
        seed    = sd;
        blk     = 0;
        mode_i  = MODE_SEL_WIDTH'(mode);
        tready  = 1'b0;
        stop_i  = 1'b0;
        start_i = 1'b1;
        s       = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;

        for (int step = 0; step < 3000 && !got_done; step++) begin
            case (ready_mode)
                0: tready = 1'b1;
                1: tready = ($urandom_range(0, 99) < 70);
                default: tready = !(cyc >= s + 2 && cyc < s + 7);
            endcase
            stop_i = 1'b0;
            if (!stop_sent && stop_beat >= 0 && (stop_in_perm ? in_perm : (accepted >= stop_beat))) begin
                stop_i    = 1'b1;
                stop_sent = 1;
                stop_cyc  = cyc;
            end
            // Stray starts while busy must be ignored; never once the final
            // beat is out, as the controller may be back in IDLE next cycle.
            start_i = rand_start && !last_seen && ($urandom_range(0, 7) == 0);

            @(negedge clk);
            if (tvalid && (!prev_valid || prev_hs)) begin
                od.push_back(tdata);
                okp.push_back(tkeep);
                ol.push_back(tlast);
                oa.push_back(cyc);
                if (tlast) last_seen = 1;
            end
            if (ready_mode == 2 && cyc >= s + 2 && cyc < s + 7 && od.size() > 0) begin
                checks++;
                if (tvalid !== 1'b1 || tdata !== od[0] || tkeep !== okp[0] || bytes_sq !== BW'(32)) begin
                    errors++;
                    $display("FAIL %s stall cyc %0d: tvalid=%b tkeep=%h bytes=%0d, required held beat 0 and bytes=32",
                             name, cyc - s, tvalid, tkeep, bytes_sq);
                end
            end
            if (prev_pd) begin
                checks++;
                if (bytes_sq !== '0) begin
                    errors++;
                    $display("FAIL %s offset after perm_done: got %0d required 0", name, bytes_sq);
                end
            end
            if (perm_start) begin
                nperm++;
                in_perm = 1;
            end
            prev_pd    = perm_done;
            prev_hs    = tvalid && tready;
            prev_valid = tvalid;
            if (prev_hs) begin
                accepted++;
                last_hs_cyc   = cyc;
                last_hs_final = tlast;
            end
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
            end
            if (!got_done) begin
                @(posedge clk); #1;
            end
        end
        start_i = 1'b0;
        stop_i  = 1'b0;

        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL %s timeout: done_o never seen, required a done pulse", name);
        end

        // Reference stream: beats of min(32, window left, digest left) bytes.
        fin = -1;
        if (shk) begin
            for (int k = 0; k < oa.size(); k++) begin
                if (stop_sent && oa[k] > stop_cyc) begin
                    fin = k;
                    break;
                end
            end
            exp_beats = fin + 1;
        end else begin
            exp_beats = (dlen + KW - 1) / KW;
        end
        off = 0; b = 0; exp_perm = 0;
        for (int k = 0; k < od.size(); k++) begin
            n = rate - off;
            if (n > KW) n = KW;
            if (!shk && dlen - off < n) n = dlen - off;
            ed = '0;
            ek = '0;
            for (int i = 0; i < n; i++) begin
                ed[i*8 +: 8] = pat(sd, b, off + i);
                ek[i]        = 1'b1;
            end
            is_last = shk ? (k == fin) : (off + n >= dlen);
            checks++;
            if (od[k] !== ed || okp[k] !== ek || ol[k] !== is_last) begin
                errors++;
                $display("FAIL %s beat %0d: got keep=%h last=%b data=%h required keep=%h last=%b data=%h",
                         name, k, okp[k], ol[k], od[k], ek, is_last, ed);
            end
            if (is_last) break;
            if (off + n >= rate) begin
                exp_perm++;
                off = 0;
                b++;
            end else begin
                off += n;
            end
        end

        checks++;
        if (exp_beats <= 0 || od.size() != exp_beats) begin
            errors++;
            $display("FAIL %s beat count: got %0d required %0d", name, od.size(), exp_beats);
        end
        checks++;
        if (nperm != exp_perm) begin
            errors++;
            $display("FAIL %s perm_start count: got %0d required %0d", name, nperm, exp_perm);
        end
        checks++;
        if (oa.size() == 0 || oa[0] != s + 2) begin
            errors++;
            $display("FAIL %s first tvalid latency: got cycle %0d required %0d", name,
                     (oa.size() > 0) ? oa[0] - s : -1, 2);
        end
        checks++;
        if (done_cyc != last_hs_cyc + 1 || !last_hs_final) begin
            errors++;
            $display("FAIL %s done timing: done at %0d final handshake at %0d last=%b, required done one cycle after final handshake",
                     name, done_cyc, last_hs_cyc, last_hs_final);
        end
        if (ready_mode == 2) begin
            checks++;
            if (oa.size() < 2 || oa[1] != s + 8) begin
                errors++;
                $display("FAIL %s beat 2 capture: got cycle %0d required %0d", name,
                         (oa.size() > 1) ? oa[1] - s : -1, 8);
            end
        end

        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tvalid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s post-done idle: busy=%b tvalid=%b done=%b required 0 0 0", name, busy, tvalid, done);
        end
        tready = 1'b0;
        $display("%s: mode %0d beats %0d perms %0d accepted %0d", name, mode, od.size(), nperm, accepted);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || tkeep !== '0 || tdata !== '0) begin
            errors++;
            $display("FAIL reset axis: tvalid=%b tlast=%b tkeep=%h required all zero", tvalid, tlast, tkeep);
        end
        checks++;
        if (bytes_sq !== '0 || perm_start !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset ctrl: bytes=%0d perm_start=%b done=%b busy=%b required all zero",
                     bytes_sq, perm_start, done, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("reset: outputs checked");
    endtask

    task automatic test_reset_mid_perm();
        bit seen;
        seen = 0;
        @(posedge clk); #1;
        seed = 7; blk = 0; perm_lat = 4;
        mode_i = MODE_SEL_WIDTH'(4);
        start_i = 1'b1;
        tready = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (perm_start) seen = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!seen || tvalid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid setup: perm_start seen=%b tvalid=%b required 1 1", seen, tvalid);
        end
        tready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || bytes_sq !== '0 || perm_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: tvalid=%b busy=%b bytes=%0d perm_start=%b required all zero",
                     tvalid, busy, bytes_sq, perm_start);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        $display("reset_mid: reset during PERM_WAIT checked");
        run_stream("after_reset_sha3_256", 1, 0, 0, -1, 0, 0);
    endtask

    initial begin
        test_reset();
        run_stream("sha3_256_linear", 1, 0, 0, -1, 0, 0);
        run_stream("sha3_512", 3, 17, 0, -1, 0, 0);
        run_stream("shake128_stream", 4, int'($urandom_range(0, 255)), 0, 9, 0, 0);
        run_stream("backpressure_sha3_512", 3, 40, 2, -1, 0, 0);
        run_stream("shake256_stop_in_perm", 5, 99, 0, 0, 1, 0);
        for (int r = 0; r < 8; r++) begin
            int m;
            m = int'($urandom_range(0, 5));
            perm_lat = int'($urandom_range(1, 6));
            run_stream($sformatf("random_%0d", r), m, int'($urandom_range(0, 255)), 1,
                       int'($urandom_range(1, 12)), shake_of(m) && ($urandom_range(0, 1) == 1), 1);
        end
        perm_lat = 4;
        test_reset_mid_perm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
